// File: rtl/ch_esteq_sched_if.sv
// Wishbone-style write bus used on both sides of the Ch_EstEqu frame
// scheduler: the upstream sample feed and the downstream estimator feed.
interface ch_esteq_sched_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] dat;
    logic          cyc;
    logic          stb;
    logic          we;
    logic          ack;

    // Bus owner: drives the cycle, strobe, write flag and data.
    modport master (
        output dat,
        output cyc,
        output stb,
        output we,
        input  ack
    );

    // Bus target: receives the transfer and answers with ack.
    modport slave (
        input  dat,
        input  cyc,
        input  stb,
        input  we,
        output ack
    );
endinterface

// File: rtl/ch_esteq_sched.sv
// Frame scheduler in front of the 802.22 channel estimator/equalizer.
// Takes the post-FFT sample stream, counts subcarriers and symbols, tags each
// sample as training or payload, and frames NPRE + nsym symbols per burst
// downstream under a single CYC envelope. A dropped upstream cycle truncates
// the frame and raises a sticky error flag.
module ch_esteq_sched #(
    parameter int NFFT   = 2048,
    parameter int NPRE   = 1,
    parameter int NSYM_W = 4,
    parameter int SC_W   = 11
) (
    input  logic                clk,
    input  logic                rst,
    ch_esteq_sched_if.slave     up,
    ch_esteq_sched_if.master    dn,
    input  logic [NSYM_W-1:0]   nsym,
    output logic                est,
    output logic [SC_W-1:0]     sc_idx,
    output logic [NSYM_W:0]     sym_idx,
    output logic                frm_done,
    output logic                err
);
    localparam int SYM_W = NSYM_W + 1;
    localparam logic [SC_W-1:0]  SC_LAST      = SC_W'(NFFT - 1);
    localparam logic [SYM_W-1:0] EST_LAST_SYM = SYM_W'(NPRE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EST   = 2'd1,
        ST_DATA  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic [31:0]         dat_r;
    logic                stb_r;
    logic                cyc_r;
    logic                est_r;
    logic [SC_W-1:0]     sc_idx_r;
    logic [SYM_W-1:0]    sym_idx_r;
    logic                frm_done_r;
    logic                err_r;

    logic [SC_W-1:0]     sc_r;
    logic [SYM_W-1:0]    sym_r;
    logic [NSYM_W-1:0]   nsym_lat_r;

    logic                ack_s;
    logic                acc_s;
    logic                xfer_s;
    logic                sc_last_s;
    logic [SYM_W-1:0]    last_data_sym_s;
    logic                tag_est_s;
    logic                start_s;
    logic                abort_s;
    logic                finish_s;

    // The output register can take a new word when it is empty or being
    // drained this cycle; FLUSH refuses input so surplus words stall upstream.
    assign ack_s  = ~rst & (state_r != ST_FLUSH) & (~stb_r | dn.ack);
    assign acc_s  = up.cyc & up.stb & up.we & ack_s;
    assign xfer_s = cyc_r & stb_r & dn.ack;

    assign sc_last_s       = (sc_r == SC_LAST);
    assign last_data_sym_s = SYM_W'(NPRE) + {1'b0, nsym_lat_r} - SYM_W'(1);

    assign up.ack   = ack_s;
    assign dn.dat   = dat_r;
    assign dn.cyc   = cyc_r;
    assign dn.stb   = stb_r;
    assign dn.we    = stb_r;
    assign est      = est_r;
    assign sc_idx   = sc_idx_r;
    assign sym_idx  = sym_idx_r;
    assign frm_done = frm_done_r;
    assign err      = err_r;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode plus the per-cycle start/abort/finish strobes and the
    // training tag attached to a word accepted this cycle.
    always_comb begin
        state_s   = state_r;
        tag_est_s = 1'b0;
        start_s   = 1'b0;
        abort_s   = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tag_est_s = (NPRE > 0) ? 1'b1 : 1'b0;
                if (acc_s) begin
                    start_s = 1'b1;
                    state_s = (NPRE > 0) ? ST_EST : ST_DATA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EST: begin
                tag_est_s = 1'b1;
                if (acc_s) begin
                    if (sc_last_s && (sym_r == EST_LAST_SYM)) begin
                        state_s = (nsym_lat_r == '0) ? ST_FLUSH : ST_DATA;
                    end else begin
                        state_s = ST_EST;
                    end
                end else if (!up.cyc) begin
                    abort_s = 1'b1;
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_EST;
                end
            end
            ST_DATA: begin
                tag_est_s = 1'b0;
                if (acc_s) begin
                    if (sc_last_s && (sym_r == last_data_sym_s)) begin
                        state_s = ST_FLUSH;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else if (!up.cyc) begin
                    abort_s = 1'b1;
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_FLUSH: begin
                if (!stb_r) begin
                    finish_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    state_s  = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Single output stage: a new word always wins over a drain, so a
    // simultaneous accept and transfer keeps STB high with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_r     <= 32'd0;
            stb_r     <= 1'b0;
            est_r     <= 1'b0;
            sc_idx_r  <= '0;
            sym_idx_r <= '0;
        end else if (acc_s) begin
            dat_r     <= up.dat;
            stb_r     <= 1'b1;
            est_r     <= tag_est_s;
            sc_idx_r  <= sc_r;
            sym_idx_r <= sym_r;
        end else if (xfer_s) begin
            stb_r     <= 1'b0;
        end
    end

    // Subcarrier/symbol position of the next accepted word; cleared when a
    // frame closes so every frame starts at sc=0, sym=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_r  <= '0;
            sym_r <= '0;
        end else if (finish_s) begin
            sc_r  <= '0;
            sym_r <= '0;
        end else if (acc_s) begin
            if (sc_last_s) begin
                sc_r  <= '0;
                sym_r <= sym_r + SYM_W'(1);
            end else begin
                sc_r  <= sc_r + SC_W'(1);
            end
        end
    end

    // Frame envelope, completion pulse, sticky truncation flag and the
    // symbol count captured on the first word of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r      <= 1'b0;
            frm_done_r <= 1'b0;
            err_r      <= 1'b0;
            nsym_lat_r <= '0;
        end else begin
            frm_done_r <= finish_s;
            if (start_s) begin
                cyc_r      <= 1'b1;
                err_r      <= 1'b0;
                nsym_lat_r <= nsym;
            end else if (finish_s) begin
                cyc_r      <= 1'b0;
            end
            if (abort_s) begin
                err_r <= 1'b1;
            end
        end
    end
endmodule

// File: doc/ch_esteq_sched.md
Name: ch_esteq_sched

Overview:
Frame scheduler placed in front of the channel estimator/equalizer (Ch_EstEqu) in the 802.22 OFDM receiver chain. It accepts the post-FFT sample stream over a Wishbone-style write interface and counts subcarriers and symbols. Each sample is tagged as training (channel estimation) or payload (equalization). The block frames exactly NPRE+NSYM symbols per burst for the downstream block, owns downstream CYC_O, and reports frame completion and truncation.

Parameters:
NFFT, 2048, subcarriers per symbol (power of two, ≥4)
NPRE, 1, training symbols at start of each frame
NSYM_W, 4, width of the data-symbol count input
SC_W, 11, log2(NFFT)

Ports:
CLK_I  in  1  clock
RST_I  in  1  synchronous active-high reset
DAT_I  in  32  upstream sample {Im[31:16], Re[15:0]}
CYC_I  in  1  upstream bus cycle
STB_I  in  1  upstream strobe
WE_I  in  1  upstream write
ACK_O  out  1  upstream accept
DAT_O  out  32  downstream sample
CYC_O  out  1  downstream bus cycle (frame envelope)
STB_O  out  1  downstream strobe
WE_O  out  1  downstream write (equals STB_O)
ACK_I  in  1  downstream accept
NSYM_I  in  NSYM_W  data symbols per frame, sampled at frame start
EST_O  out  1  current DAT_O belongs to a training symbol
SC_IDX_O  out  SC_W  subcarrier index of DAT_O
SYM_IDX_O  out  NSYM_W+1  symbol index of DAT_O (training symbols first)
FRM_DONE_O  out  1  one-cycle pulse at frame end
ERR_O  out  1  sticky: frame truncated by CYC_I drop

Behaviour:
- One clock domain (CLK_I). RST_I is synchronous, active-high, and overrides everything, including mid-frame.
- Reset values: ACK_O=0, CYC_O=0, STB_O=0, WE_O=0, DAT_O=0, EST_O=0, SC_IDX_O=0, SYM_IDX_O=0, FRM_DONE_O=0, ERR_O=0. State=IDLE, all counters 0.
- Upstream accept: acc = CYC_I & STB_I & WE_I & ACK_O.
- Downstream transfer: xfer = CYC_O & STB_O & ACK_I.
- Single registered output stage. ACK_O = (state ∈ {IDLE, EST, DATA}) & (~STB_O | ACK_I), so full throughput applies when ACK_I=1.
- Latency: a sample accepted at edge k appears on DAT_O/STB_O after edge k, with its tags (EST_O, SC_IDX_O, SYM_IDX_O) registered alongside. Output holds stable while STB_O & ~ACK_I.
- Counters: sc increments on acc and wraps from NFFT-1 to 0. On each wrap, sym increments.
- FSM states:
  - IDLE: CYC_O=0. The first acc latches nsym_lat = NSYM_I, clears ERR_O, takes the sample as sc=0/sym=0, asserts CYC_O with STB_O, and goes to EST (to DATA if NPRE=0).
  - EST: EST tag=1. On acc with sc=NFFT-1 and sym=NPRE-1, go to DATA. If nsym_lat=0, go to FLUSH instead.
  - DATA: EST tag=0. On acc with sc=NFFT-1 and sym=NPRE+nsym_lat-1, go to FLUSH.
  - FLUSH: ACK_O=0, so extra upstream words stall and are not lost. When STB_O=0 (last word drained), deassert CYC_O, pulse FRM_DONE_O for 1 cycle, clear counters, go to IDLE.
- Abort: in EST or DATA with CYC_I=0 (no acc), set ERR_O=1 and go to FLUSH. Buffered data still drains, and FRM_DONE_O still pulses.
- CYC_O stays high for the whole frame, including bubbles. It falls on the edge after the last xfer.
- Simultaneous acc and xfer in the same cycle: the new word replaces the old, STB_O stays 1, and no bubble is inserted.
- ERR_O clears only on reset or on the first acc of the next frame.

Test Plan:
- NFFT=2048, NPRE=1, NSYM_I=5, 12288 contiguous words, ACK_I=1 → 12288 xfers. EST_O=1 for outputs 0..2047, 0 after. SYM_IDX_O runs 0..5. CYC_O falls 1 cycle after the final xfer, FRM_DONE_O pulses once, ERR_O=0.
- Same stimulus with ACK_I toggled randomly 50% → output sequence and tags identical to the previous case. No word is duplicated or dropped, and DAT_O is stable during every stall.
- NSYM_I=0 → exactly 2048 xfers, all with EST_O=1, then FRM_DONE_O. A 2049th word presented upstream sees ACK_O=0 until FLUSH completes, then starts a new frame at sc=0.
- CYC_I dropped after 3000 words, NSYM_I=5 → 3000 xfers, ERR_O=1, FRM_DONE_O pulse. ERR_O clears on the first word of the next frame.
- RST_I asserted for 1 cycle mid-DATA (word 5000) → on the next edge all outputs take reset values. The following frame restarts with SYM_IDX_O=0, SC_IDX_O=0.
- NSYM_I changed mid-frame from 5 to 2 → the current frame still totals 12288 words, and the next frame uses 2 (6144 words).
